seg_p2s_shifter: RTL and testbench
==================================

Name: seg_p2s_shifter

Overview:
- Parallel-to-serial transmitter that drives the board's chained 74HC164-style segment shift registers.
- Takes the 64-bit segment image produced by the hex-to-segment encoding stage (8 digits x {a,b,c,d,e,f,g,p}).
- Shifts the image out bit-serially with a generated serial clock, then pulses a latch/enable strobe so the external registers present the new image.
- Sits between the display encoder and the top-level pins.

Parameters:
- DATA_WIDTH, 64, number of bits shifted per frame (>=2).
- CLK_DIV, 2, half-period of the serial clock in clk cycles (>=1).
- REFRESH_CYCLES, 100000, auto-refresh interval in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one frame transfer; sampled only in IDLE.
- par_data  input  DATA_WIDTH  segment image; captured on the accepted start cycle.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.
- s_clk  output  1  serial clock to the external shift registers.
- s_out  output  1  serial data, valid around the s_clk rising edge.
- s_en  output  1  latch/enable strobe to the external registers.
- s_clrn  output  1  active-low clear of the external registers.

Behaviour:
- Reset values (rst high at a clk edge): state=IDLE, busy=0, done=0, s_clk=0, s_out=0, s_en=0, s_clrn=0, shift register=0, counters=0.
- s_clrn is registered ~rst: 0 during every reset cycle, 1 from the first edge with rst low.
- All outputs are registered; no combinational path from inputs to outputs.

State machine:
- IDLE:
  - busy=0, s_clk=0, s_en=0.
  - If start=1: capture par_data, clear bit counter, go to SHIFT_LO. busy=1 from the next cycle.
- SHIFT_LO:
  - s_clk=0, s_out=shreg[0] (LSB first).
  - Stay CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - s_clk=1; s_out is held stable, so the external rising edge samples a settled bit.
  - After CLK_DIV cycles, shift shreg right by 1 and increment the bit counter.
  - If the counter was DATA_WIDTH-1, go to LATCH; otherwise go to SHIFT_LO.
- LATCH:
  - s_clk=0, s_out=0, s_en=1 for 2*CLK_DIV cycles, then go to IDLE.
  - On that transition done=1 for exactly one cycle (the first IDLE cycle), with busy=0 in the same cycle.

Timing:
- busy is high for exactly DATA_WIDTH*2*CLK_DIV + 2*CLK_DIV cycles per frame.
- With defaults this is 260 cycles.
- Exactly DATA_WIDTH rising edges on s_clk per frame; none outside SHIFT_HI entry.

Boundary conditions:
- start while busy=1 is ignored, not queued. par_data changes during a frame have no effect.
- start in the same cycle as done=1 is accepted (the machine is in IDLE); back-to-back frames are separated by exactly one IDLE cycle.
- rst mid-frame aborts immediately:
  - All outputs take reset values on that edge.
  - No done pulse.
  - s_clrn=0 clears the partially shifted external registers.
- start held high continuously causes continuous frames.
- The bit counter width is clog2(DATA_WIDTH); it must not wrap before the LATCH decision.

Optional Feature:
- Macro: SEG_P2S_AUTO_REFRESH_EN.
- Defined:
  - A free-running counter counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap, if in IDLE, an internal start is generated (ORed with the start port). If not in IDLE, that tick is dropped.
  - The counter resets to 0 on rst.
  - Lets the display refresh with no external sequencer.
- Undefined: no counter logic is synthesized; transfers occur only on the start port.

Test Plan:
1. Reset and clear: rst held 3 cycles, then released.
   -> All outputs 0 during reset; s_clrn=1 from the first cycle after release; busy stays 0 with start=0.
2. Single frame, defaults: par_data=64'h0123_4567_89AB_CDEF, one-cycle start.
   -> busy high for 260 cycles; 64 s_clk rising edges.
   -> s_out sampled at rising edges reconstructs 64'h0123_4567_89AB_CDEF LSB-first (first bit 1, second bit 1, third 1, fourth 1, fifth 0).
   -> s_en high for 4 cycles after the last edge; done pulse of 1 cycle.
3. Ignore while busy: start at frame cycle 50 with a different par_data.
   -> No effect: still 64 edges, original data, a single done.
4. Back-to-back: start held high for 600 cycles, CLK_DIV=1, DATA_WIDTH=8.
   -> Frames of 18 busy cycles separated by 1 idle cycle; done pulses 19 cycles apart.
5. Reset mid-frame: assert rst at bit 20 of a frame.
   -> Next edge: s_clk=0, s_en=0, busy=0, s_clrn=0; no done.
   -> A new start after release transmits a full, correct frame.
6. With SEG_P2S_AUTO_REFRESH_EN and REFRESH_CYCLES=1000, start tied 0.
   -> Frames begin every 1000 cycles; done count = 3 after 3000+260 cycles.

Source files
------------

// File: rtl/seg_p2s_shifter.sv
// seg_p2s_shifter: parallel-to-serial transmitter for chained 74HC164-style
// segment shift registers. It captures a DATA_WIDTH-bit segment image and
// shifts it out LSB first on s_out, with s_clk generated at a half-period of
// CLK_DIV clk cycles. It then holds s_en high for 2*CLK_DIV cycles so the
// external registers present the new image.
//
// Optional feature: define SEG_P2S_AUTO_REFRESH_EN to add a free-running
// counter that requests a frame every REFRESH_CYCLES clk cycles. The request
// is ORed with the start port and is dropped if the machine is not in IDLE.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     frame request, sampled only in IDLE
//   par_data  segment image, captured on the accepted start cycle
//   busy      high while a frame is in progress
//   done      one-cycle pulse on the first IDLE cycle after a frame
//   s_clk     serial clock to the external registers
//   s_out     serial data, stable across the s_clk rising edge
//   s_en      latch/enable strobe
//   s_clrn    active-low clear of the external registers (registered ~rst)
module seg_p2s_shifter #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned REFRESH_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] par_data,
  output logic                  busy,
  output logic                  done,
  output logic                  s_clk,
  output logic                  s_out,
  output logic                  s_en,
  output logic                  s_clrn
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic                    busy_d, done_d, s_clk_d, s_out_d, s_en_d;
  logic                    start_req;

`ifdef SEG_P2S_AUTO_REFRESH_EN
  localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  logic [REF_W-1:0] ref_cnt_q;
  logic             ref_tick;

  // Free-running refresh timer; its wrap doubles as an internal start.
  assign ref_tick = (ref_cnt_q == REF_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q <= '0;
    end else if (ref_tick) begin
      ref_cnt_q <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_q + REF_W'(1);
    end
  end

  assign start_req = start | ref_tick;
`else
  // Keeps the refresh parameter referenced when the timer is compiled out.
  logic unused_refresh;
  assign unused_refresh = ^{1'b0, 32'(REFRESH_CYCLES)};

  assign start_req = start;
`endif

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          shreg_d   = par_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_cnt_q == HALF_LAST) begin
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_cnt_q == HALF_LAST) begin
          div_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          // Decide on the pre-increment count so a power-of-two width never wraps first.
          state_d   = (bit_cnt_q == BIT_LAST) ? LATCH : SHIFT_LO;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_cnt_q == LATCH_LAST) begin
          div_cnt_d = '0;
          state_d   = IDLE;
          done_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up with it.
    busy_d  = (state_d != IDLE);
    s_clk_d = (state_d == SHIFT_HI);
    s_en_d  = (state_d == LATCH);
    s_out_d = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shreg_d[0] : 1'b0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s_clk     <= 1'b0;
      s_out     <= 1'b0;
      s_en      <= 1'b0;
      s_clrn    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      s_clk     <= s_clk_d;
      s_out     <= s_out_d;
      s_en      <= s_en_d;
      s_clrn    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_p2s_shifter.sv
// Directed bench for seg_p2s_shifter: a default instance (64 bits, CLK_DIV=2),
// a small instance (8 bits, CLK_DIV=1) for back-to-back framing, and an
// instance with REFRESH_CYCLES=1000 for the optional auto-refresh.
module tb_seg_p2s_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mon_clr;

  logic        start_a;
  logic [63:0] data_a;
  logic        busy_a, done_a, sclk_a, sout_a, sen_a, sclrn_a;

  logic        start_b;
  logic [7:0]  data_b;
  logic        busy_b, done_b, sclk_b, sout_b, sen_b, sclrn_b;

  logic        start_r;
  logic [63:0] data_r;
  logic        busy_r, done_r, sclk_r, sout_r, sen_r, sclrn_r;

  seg_p2s_shifter #(.DATA_WIDTH(64), .CLK_DIV(2), .REFRESH_CYCLES(100000)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .par_data(data_a),
    .busy(busy_a), .done(done_a), .s_clk(sclk_a), .s_out(sout_a),
    .s_en(sen_a), .s_clrn(sclrn_a)
  );

  seg_p2s_shifter #(.DATA_WIDTH(8), .CLK_DIV(1), .REFRESH_CYCLES(100000)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .par_data(data_b),
    .busy(busy_b), .done(done_b), .s_clk(sclk_b), .s_out(sout_b),
    .s_en(sen_b), .s_clrn(sclrn_b)
  );

  seg_p2s_shifter #(.DATA_WIDTH(64), .CLK_DIV(2), .REFRESH_CYCLES(1000)) u_dut_r (
    .clk(clk), .rst(rst), .start(start_r), .par_data(data_r),
    .busy(busy_r), .done(done_r), .s_clk(sclk_r), .s_out(sout_r),
    .s_en(sen_r), .s_clrn(sclrn_r)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  // Instance A monitor: s_clk rising edges, received bits, strobe/busy/done counts.
  int          edges_a, busy_cyc_a, en_cyc_a, dones_a, ovl_a;
  logic [63:0] rx_a;
  logic        sclk_prev_a = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      edges_a = 0; busy_cyc_a = 0; en_cyc_a = 0; dones_a = 0; ovl_a = 0; rx_a = '0;
    end else begin
      if (sclk_a && !sclk_prev_a) begin
        edges_a++;
        rx_a = {sout_a, rx_a[63:1]};
      end
      if (busy_a) busy_cyc_a++;
      if (sen_a) en_cyc_a++;
      if (done_a) dones_a++;
      if (done_a && busy_a) ovl_a++;
    end
    sclk_prev_a = sclk_a;
  end

  // Instance B monitor: busy run lengths and done spacing.
  int         edges_b, dones_b, runs_b, run_b, bad_run_b, bad_gap_b, cyc_b, last_done_b;
  logic [7:0] rx_b;
  logic       sclk_prev_b = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      edges_b = 0; dones_b = 0; runs_b = 0; run_b = 0; bad_run_b = 0; bad_gap_b = 0;
      cyc_b = 0; last_done_b = -1; rx_b = '0;
    end else begin
      if (sclk_b && !sclk_prev_b) begin
        edges_b++;
        rx_b = {sout_b, rx_b[7:1]};
      end
      if (busy_b) begin
        run_b++;
      end else if (run_b != 0) begin
        runs_b++;
        if (run_b != 18) bad_run_b++;
        run_b = 0;
      end
      if (done_b) begin
        if (last_done_b >= 0 && (cyc_b - last_done_b) != 19) bad_gap_b++;
        last_done_b = cyc_b;
        dones_b++;
      end
      cyc_b++;
    end
    sclk_prev_b = sclk_b;
  end

  // Instance R monitor: done pulses only.
  int dones_r;
  always @(negedge clk) begin
    if (mon_clr) dones_r = 0;
    else if (done_r) dones_r++;
  end

  initial begin
    rst = 1'b1; mon_clr = 1'b1;
    start_a = 1'b0; data_a = '0;
    start_b = 1'b0; data_b = '0;
    start_r = 1'b0; data_r = 64'hFFFF_0000_FFFF_0000;

    // Reset and clear.
    tick(1);
    check("rst_busy",  busy_a,  1'b0);
    check("rst_sclk",  sclk_a,  1'b0);
    check("rst_sen",   sen_a,   1'b0);
    check("rst_sout",  sout_a,  1'b0);
    check("rst_done",  done_a,  1'b0);
    tick(2);
    check("rst_clrn",  sclrn_a, 1'b0);
    rst = 1'b0;
    tick(1);
    check("rel_clrn",  sclrn_a, 1'b1);
    check("rel_busy",  busy_a,  1'b0);
    clear_mon();
    tick(5);
    check("idle_done", dones_a, 0);
    check("idle_busy", busy_a,  1'b0);

    // Single frame with default parameters.
    clear_mon();
    data_a = 64'h0123_4567_89AB_CDEF;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    check("f1_busy_rise", busy_a, 1'b1);
    for (int i = 0; i < 400 && dones_a < 1; i++) tick(1);
    tick(4);
    check("f1_edges",   edges_a,    64);
    check("f1_data",    rx_a,       64'h0123_4567_89AB_CDEF);
    check("f1_busy",    busy_cyc_a, 260);
    check("f1_sen",     en_cyc_a,   4);
    check("f1_done",    dones_a,    1);
    check("f1_overlap", ovl_a,      0);

    // start and par_data changes during a frame are ignored.
    clear_mon();
    data_a = 64'hDEAD_BEEF_F00D_CAFE;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(49);
    data_a = 64'h1111_2222_3333_4444;
    start_a = 1'b1;
    tick(3);
    start_a = 1'b0;
    for (int i = 0; i < 400 && dones_a < 1; i++) tick(1);
    tick(20);
    check("ign_edges", edges_a,    64);
    check("ign_data",  rx_a,       64'hDEAD_BEEF_F00D_CAFE);
    check("ign_done",  dones_a,    1);
    check("ign_busy",  busy_cyc_a, 260);

    // Back-to-back frames with start held high (8 bits, CLK_DIV=1).
    clear_mon();
    data_b = 8'hA5;
    start_b = 1'b1;
    tick(600);
    start_b = 1'b0;
    tick(40);
    check("b2b_done",    dones_b,   32);
    check("b2b_runs",    runs_b,    32);
    check("b2b_badrun",  bad_run_b, 0);
    check("b2b_badgap",  bad_gap_b, 0);
    check("b2b_edges",   edges_b,   256);
    check("b2b_data",    rx_b,      8'hA5);

    // Reset mid-frame at bit 20.
    clear_mon();
    data_a = 64'hCAFE_BABE_1234_5678;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    for (int i = 0; i < 200 && edges_a < 20; i++) tick(1);
    check("mid_edges", edges_a, 20);
    rst = 1'b1;
    tick(1);
    check("mid_sclk", sclk_a,  1'b0);
    check("mid_sen",  sen_a,   1'b0);
    check("mid_busy", busy_a,  1'b0);
    check("mid_clrn", sclrn_a, 1'b0);
    check("mid_sout", sout_a,  1'b0);
    rst = 1'b0;
    tick(300);
    check("mid_nodone", dones_a, 0);
    check("mid_idle",   busy_a,  1'b0);

    clear_mon();
    data_a = 64'h8000_0000_0000_0001;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    for (int i = 0; i < 400 && dones_a < 1; i++) tick(1);
    tick(2);
    check("post_edges", edges_a, 64);
    check("post_data",  rx_a,    64'h8000_0000_0000_0001);
    check("post_done",  dones_a, 1);

`ifdef SEG_P2S_AUTO_REFRESH_EN
    // Auto-refresh: a frame every 1000 cycles with start tied low.
    rst = 1'b1; mon_clr = 1'b1;
    tick(2);
    rst = 1'b0; mon_clr = 1'b0;
    tick(3300);
    check("auto_done", dones_r, 3);
`else
    // Without auto-refresh, an instance with start tied low never transmits.
    clear_mon();
    tick(1200);
    check("noauto_done", dones_r, 0);
    check("noauto_busy", busy_r,  1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
